// File: rtl/alu_mc_hs.sv
// Multi-cycle ALU with valid/ready handshakes on both sides: 1-cycle add/sub/logic ops,
// iterative shift-add multiply and (when ALU_DIV_EN is defined) restoring divide.
module alu_mc_hs #(
  parameter int WIDTH = 8
) (
  input  logic               CLk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         op_code,
  input  logic               C_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Result,
  output logic               C_out,
  output logic               Z_flag,
  output logic               Err
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] result_q;
  logic               c_out_q;
  logic               z_q;
  logic               err_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CW-1:0]      cnt_q;
`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q;
`endif

  logic [WIDTH:0]     add_sum_d;
  logic [WIDTH-1:0]   sub_diff_d;
  logic [2*WIDTH-1:0] fast_res_d;
  logic               fast_cout_d;
  logic               fast_err_d;
  logic               fast_multi_d;
  logic [2*WIDTH-1:0] p_init_d;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] mul_next_d;
  logic [2*WIDTH-1:0] iter_next_d;

  assign add_sum_d  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C_in};
  assign sub_diff_d = A - B;

  // One-cycle results, computed straight from the operands presented at acceptance.
  always_comb begin
    fast_res_d   = '0;
    fast_cout_d  = 1'b0;
    fast_err_d   = 1'b0;
    fast_multi_d = 1'b0;
    p_init_d     = {{WIDTH{1'b0}}, B};
    case (op_code)
      4'd0: begin
        fast_res_d  = {{(WIDTH-1){1'b0}}, add_sum_d};
        fast_cout_d = add_sum_d[WIDTH];
      end
      4'd1: begin
        fast_res_d  = {{WIDTH{1'b0}}, sub_diff_d};
        fast_cout_d = (A < B);
      end
      4'd2: fast_multi_d = 1'b1;
`ifdef ALU_DIV_EN
      4'd3: begin
        p_init_d = {{WIDTH{1'b0}}, A};
        if (B == {WIDTH{1'b0}}) begin
          fast_res_d = {A, {WIDTH{1'b1}}};
          fast_err_d = 1'b1;
        end else begin
          fast_multi_d = 1'b1;
        end
      end
`endif
      4'd4: fast_res_d = {{WIDTH{1'b0}}, A & B};
      4'd5: fast_res_d = {{WIDTH{1'b0}}, A ^ B};
      4'd6: fast_res_d = {{WIDTH{1'b0}}, A | B};
      default: fast_err_d = 1'b1;
    endcase
  end

  // Multiply step: p holds {partial product high half, remaining multiplier bits}.
  assign mul_sum_d  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_next_d = {mul_sum_d, p_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  logic [WIDTH:0]     r_shift_d;
  logic [WIDTH:0]     r_sub_d;
  logic               r_ge_d;
  logic [2*WIDTH-1:0] div_next_d;

  // Restoring divide step: p holds {remainder, dividend bits shifting into quotient}.
  assign r_shift_d  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign r_ge_d     = (r_shift_d >= {1'b0, b_q});
  assign r_sub_d    = r_shift_d - {1'b0, b_q};
  assign div_next_d = {(r_ge_d ? r_sub_d[WIDTH-1:0] : r_shift_d[WIDTH-1:0]), p_q[WIDTH-2:0], r_ge_d};
  assign iter_next_d = is_div_q ? div_next_d : mul_next_d;
`else
  assign iter_next_d = mul_next_d;
`endif

  // Handshake FSM with registered outputs and iterative datapath.
  always_ff @(posedge CLk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      c_out_q     <= 1'b0;
      z_q         <= 1'b1;
      err_q       <= 1'b0;
      a_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
`ifdef ALU_DIV_EN
      b_q         <= '0;
      is_div_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (fast_multi_d) begin
              state_q <= S_BUSY;
              a_q     <= A;
              p_q     <= p_init_d;
              cnt_q   <= '0;
`ifdef ALU_DIV_EN
              b_q      <= B;
              is_div_q <= (op_code == 4'd3);
`endif
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= fast_res_d;
              c_out_q     <= fast_cout_d;
              err_q       <= fast_err_d;
              z_q         <= (fast_res_d == '0);
            end
          end
        end
        S_BUSY: begin
          p_q   <= iter_next_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= iter_next_d;
            c_out_q     <= 1'b0;
            err_q       <= 1'b0;
            z_q         <= (iter_next_d == '0);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign C_out     = c_out_q;
  assign Z_flag    = z_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_alu_mc_hs.sv
// Self-checking bench for alu_mc_hs (WIDTH=8): directed vectors, back-pressure,
// reset abort and random ops checked against an arithmetic reference model.
module tb_alu_mc_hs;

  localparam int W = 8;

  logic           CLk = 1'b0;
  logic           Reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [3:0]     op_code;
  logic           C_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] Result;
  logic           C_out;
  logic           Z_flag;
  logic           Err;

  int checks = 0;
  int errors = 0;

  alu_mc_hs #(.WIDTH(W)) dut (
    .CLk(CLk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op_code(op_code), .C_in(C_in), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .C_out(C_out), .Z_flag(Z_flag), .Err(Err)
  );

  always #5 CLk = ~CLk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model from the operation table, using plain integer arithmetic.
  task automatic model(input logic [3:0] op, input int a, input int b, input logic cin,
                       output logic [15:0] r, output logic c, output logic e, output int lat);
    int t;
    r = 16'h0000; c = 1'b0; e = 1'b0; lat = 1;
    case (op)
      4'd0: begin t = a + b + int'(cin); r = 16'(t); c = (t > 255); end
      4'd1: begin t = (a - b + 256) % 256; r = 16'(t); c = (a < b); end
      4'd2: begin r = 16'(a * b); lat = 9; end
`ifdef ALU_DIV_EN
      4'd3: begin
        if (b == 0) begin r = 16'(a * 256 + 255); e = 1'b1; end
        else begin r = 16'((a % b) * 256 + a / b); lat = 9; end
      end
`endif
      4'd4: r = 16'(a & b);
      4'd5: r = 16'(a ^ b);
      4'd6: r = 16'(a | b);
      default: e = 1'b1;
    endcase
  endtask

  // Issue one op, check latency/result/flags, optionally hold out_ready low, then drain.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, input int hold);
    logic [15:0] er;
    logic ec, ee;
    int elat, lat, tmo, busy_bad;
    model(op, int'(a), int'(b), cin, er, ec, ee, elat);
    tmo = 0;
    while (!in_ready && tmo < 50) begin @(posedge CLk); #1; tmo++; end
    check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op_code = op; A = a; B = b; C_in = cin;
    @(posedge CLk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; op_code = 4'($urandom); C_in = 1'($urandom);
    lat = 1; busy_bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(posedge CLk); #1; lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busy_ready"}, 32'(busy_bad), 32'd0);
    check({tag, "_result"}, 32'(Result), 32'(er));
    check({tag, "_flags"}, {29'd0, C_out, Z_flag, Err}, {29'd0, ec, (er == 16'h0000), ee});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; A = $urandom; op_code = 4'd0;
      @(posedge CLk); #1;
      check({tag, "_hold"}, {13'd0, out_valid, in_ready, C_out, Result}, {13'd0, 1'b1, 1'b0, ec, er});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge CLk); #1;
    out_ready = 1'b0;
    check({tag, "_drain"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 8'h00; B = 8'h00; op_code = 4'd0; C_in = 1'b0;
    #12;
    check("reset_state", {12'd0, in_ready, out_valid, C_out, Z_flag, Err, 1'b0, Result},
          {12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    @(posedge CLk); #1; Reset = 1'b1;
    @(posedge CLk); #1;

    do_op("add_ff_01_c", 4'd0, 8'hFF, 8'h01, 1'b1, 0);
    do_op("sub_03_05",   4'd1, 8'h03, 8'h05, 1'b0, 0);
    do_op("sub_05_05",   4'd1, 8'h05, 8'h05, 1'b0, 0);
    do_op("mul_ff_ff",   4'd2, 8'hFF, 8'hFF, 1'b0, 0);
    do_op("div_c8_07",   4'd3, 8'hC8, 8'h07, 1'b0, 0);
    do_op("div_c8_00",   4'd3, 8'hC8, 8'h00, 1'b0, 0);
    do_op("add_bp",      4'd0, 8'h01, 8'h01, 1'b0, 5);
    do_op("illegal_9",   4'd9, 8'h5A, 8'hA5, 1'b1, 0);
    do_op("illegal_f",   4'd15, 8'h11, 8'h22, 1'b0, 0);
    do_op("and",         4'd4, 8'hF0, 8'h3C, 1'b0, 0);
    do_op("xor",         4'd5, 8'hAA, 8'hAA, 1'b0, 0);
    do_op("or",          4'd6, 8'h0F, 8'h30, 1'b0, 0);
    do_op("mul_zero",    4'd2, 8'h00, 8'h9B, 1'b0, 0);
    do_op("div_small",   4'd3, 8'h05, 8'hFE, 1'b0, 0);

    // Reset during a multiply must abort it.
    in_valid = 1'b1; op_code = 4'd2; A = 8'h12; B = 8'h34; C_in = 1'b0;
    @(posedge CLk); #1; in_valid = 1'b0;
    repeat (3) @(posedge CLk);
    #1; Reset = 1'b0; #1;
    check("abort_in_reset", {13'd0, out_valid, Z_flag, in_ready, Result},
          {13'd0, 1'b0, 1'b1, 1'b1, 16'h0000});
    repeat (4) @(posedge CLk);
    #1; Reset = 1'b1;
    check("abort_release", {14'd0, out_valid, in_ready, Result}, {14'd0, 1'b0, 1'b1, 16'h0000});
    repeat (12) @(posedge CLk);
    #1;
    check("abort_no_result", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    do_op("add_after_rst", 4'd0, 8'h21, 8'h43, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] rop;
      logic [7:0] rb;
      rop = 4'($urandom_range(0, 9));
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_op("rand", rop, 8'($urandom), rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
